// File: rtl/tetris_cmd_arbiter.sv
// Merges button, UART and gravity requests into one valid/ack command stream for the tetris engine.
// Each source has a one-entry slot. RESTART overrides round-robin, and game_over silences everything except RESTART.
module tetris_cmd_arbiter #(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned DROP_W      = 8
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic [3:0]        btn_req,
  input  logic              uart_valid,
  input  logic [2:0]        uart_cmd,
  output logic              uart_ready,
  input  logic              engine_ready,
  input  logic              game_over,
  output logic              cmd_valid,
  output logic [2:0]        cmd,
  input  logic              cmd_ack,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_LEFT    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_ROTATE  = 3'd3;
  localparam logic [2:0] CMD_DOWN    = 3'd4;
  localparam logic [2:0] CMD_DROP    = 3'd5;
  localparam logic [2:0] CMD_RESTART = 3'd7;

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef enum logic [1:0] {SRC_GRAV = 2'd0, SRC_BTN = 2'd1, SRC_UART = 2'd2} src_t;

  state_t            state_q, state_d;
  src_t              rr_q, rr_d;
  logic [CNT_W-1:0]  grav_cnt_q, grav_cnt_d;
  logic              grav_pend_q, grav_pend_d;
  logic              btn_full_q, btn_full_d;
  logic [2:0]        btn_code_q, btn_code_d;
  logic              uart_full_q, uart_full_d;
  logic [2:0]        uart_code_q, uart_code_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic       grav_elig, btn_elig, uart_elig;
  logic       gnt_any;
  src_t       gnt_src;
  logic       gnt_grav, gnt_btn, gnt_uart;
  logic [2:0] btn_load_code;
  logic       btn_extra, btn_hold, uart_hold, uart_load, grav_wrap;

  // Under game_over only a held RESTART stays eligible; everything else is being discarded.
  always_comb begin
    grav_elig = grav_pend_q && !game_over;
    btn_elig  = btn_full_q && (!game_over || btn_code_q == CMD_RESTART);
    uart_elig = uart_full_q && (!game_over || uart_code_q == CMD_RESTART);
    gnt_any   = 1'b0;
    gnt_src   = rr_q;
    if (state_q == IDLE && engine_ready) begin
      if (btn_elig && btn_code_q == CMD_RESTART) begin
        gnt_any = 1'b1; gnt_src = SRC_BTN;
      end else if (uart_elig && uart_code_q == CMD_RESTART) begin
        gnt_any = 1'b1; gnt_src = SRC_UART;
      end else begin
        case (rr_q)
          SRC_GRAV: begin
            if (grav_elig)      begin gnt_any = 1'b1; gnt_src = SRC_GRAV; end
            else if (btn_elig)  begin gnt_any = 1'b1; gnt_src = SRC_BTN;  end
            else if (uart_elig) begin gnt_any = 1'b1; gnt_src = SRC_UART; end
          end
          SRC_BTN: begin
            if (btn_elig)       begin gnt_any = 1'b1; gnt_src = SRC_BTN;  end
            else if (uart_elig) begin gnt_any = 1'b1; gnt_src = SRC_UART; end
            else if (grav_elig) begin gnt_any = 1'b1; gnt_src = SRC_GRAV; end
          end
          default: begin
            if (uart_elig)      begin gnt_any = 1'b1; gnt_src = SRC_UART; end
            else if (grav_elig) begin gnt_any = 1'b1; gnt_src = SRC_GRAV; end
            else if (btn_elig)  begin gnt_any = 1'b1; gnt_src = SRC_BTN;  end
          end
        endcase
      end
    end
  end

  assign gnt_grav = gnt_any && (gnt_src == SRC_GRAV);
  assign gnt_btn  = gnt_any && (gnt_src == SRC_BTN);
  assign gnt_uart = gnt_any && (gnt_src == SRC_UART);

  always_comb begin
    btn_load_code = CMD_NONE;
    btn_extra     = 1'b0;
    if (btn_req[0]) begin
      btn_load_code = CMD_LEFT;   btn_extra = |btn_req[3:1];
    end else if (btn_req[1]) begin
      btn_load_code = CMD_RIGHT;  btn_extra = |btn_req[3:2];
    end else if (btn_req[2]) begin
      btn_load_code = CMD_ROTATE; btn_extra = btn_req[3];
    end else if (btn_req[3]) begin
      btn_load_code = CMD_DROP;
    end
  end

  // A granted slot is free for a same-cycle load.
  assign btn_hold   = btn_full_q && !gnt_btn && !(game_over && btn_code_q != CMD_RESTART);
  assign uart_hold  = uart_full_q && !gnt_uart && !(game_over && uart_code_q != CMD_RESTART);
  assign uart_ready = !uart_full_q || gnt_uart;
  assign uart_load  = uart_valid && uart_ready && (uart_cmd != CMD_NONE) &&
                      (!game_over || uart_cmd == CMD_RESTART);
  assign grav_wrap  = (grav_cnt_q == CNT_W'(TICK_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    drop_cnt_d  = drop_cnt_q;
    grav_cnt_d  = grav_cnt_q;
    grav_pend_d = grav_pend_q;
    btn_full_d  = btn_hold;
    btn_code_d  = btn_code_q;
    uart_full_d = uart_hold;
    uart_code_d = uart_code_q;

    case (state_q)
      IDLE: if (gnt_any) begin
        state_d     = ISSUE;
        cmd_valid_d = 1'b1;
        case (gnt_src)
          SRC_GRAV: begin cmd_d = CMD_DOWN;    rr_d = SRC_BTN;  end
          SRC_BTN:  begin cmd_d = btn_code_q;  rr_d = SRC_UART; end
          default:  begin cmd_d = uart_code_q; rr_d = SRC_GRAV; end
        endcase
      end
      default: if (cmd_ack) begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
        cmd_d       = CMD_NONE;
      end
    endcase

    if (game_over) begin
      grav_cnt_d  = '0;
      grav_pend_d = 1'b0;
    end else begin
      grav_cnt_d  = grav_wrap ? '0 : grav_cnt_q + CNT_W'(1);
      grav_pend_d = (grav_pend_q && !gnt_grav) || grav_wrap;
    end

    // Button codes never map to RESTART, so game_over discards every button load.
    if ((|btn_req) && !btn_hold) begin
      btn_full_d = !game_over;
      btn_code_d = btn_load_code;
    end
    if ((|btn_req) && (btn_hold || btn_extra) && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + DROP_W'(1);

    if (uart_load) begin
      uart_full_d = 1'b1;
      uart_code_d = uart_cmd;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= SRC_GRAV;
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
      btn_full_q  <= 1'b0;
      btn_code_q  <= CMD_NONE;
      uart_full_q <= 1'b0;
      uart_code_q <= CMD_NONE;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NONE;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      btn_full_q  <= btn_full_d;
      btn_code_q  <= btn_code_d;
      uart_full_q <= uart_full_d;
      uart_code_q <= uart_code_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_tetris_cmd_arbiter.sv
// Scoreboard bench for tetris_cmd_arbiter: a slot-level reference model queues expected commands,
// and a negedge monitor compares each offered command against the queue head.
module tb_tetris_cmd_arbiter;

  localparam int TICK = 8;
  localparam int DW   = 4;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk_50MHz;
  logic          reset_n;
  logic [3:0]    btn_req;
  logic          uart_valid;
  logic [2:0]    uart_cmd;
  logic          uart_ready;
  logic          engine_ready;
  logic          game_over;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic          cmd_ack;
  logic [DW-1:0] drop_cnt;

  tetris_cmd_arbiter #(.TICK_CYCLES(TICK), .DROP_W(DW)) dut (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n), .btn_req(btn_req),
    .uart_valid(uart_valid), .uart_cmd(uart_cmd), .uart_ready(uart_ready),
    .engine_ready(engine_ready), .game_over(game_over), .cmd_valid(cmd_valid),
    .cmd(cmd), .cmd_ack(cmd_ack), .drop_cnt(drop_cnt)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  // Reference model: slot contents as codes (0 = empty); index 0 GRAV, 1 BTN, 2 UART.
  int m_slot[3] = '{0, 0, 0};
  int m_grav    = 0;
  int m_rr      = 0;
  bit m_busy    = 1'b0;
  int m_drop    = 0;
  bit m_flush   = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic bit elig(input int code);
    return (code != 0) && (!game_over || code == 7);
  endfunction

  task automatic model_step();
    int g;
    int low;
    bit rdy;
    g = -1;
    if (!m_busy && engine_ready) begin
      if (elig(m_slot[1]) && m_slot[1] == 7) g = 1;
      else if (elig(m_slot[2]) && m_slot[2] == 7) g = 2;
      else for (int k = 0; k < 3; k++)
        if (g < 0 && elig(m_slot[(m_rr + k) % 3])) g = (m_rr + k) % 3;
    end
    rdy = (m_slot[2] == 0) || (g == 2);
    checkOutput("uart_ready", int'(uart_ready), int'(rdy));
    if (!reset_n) begin
      m_slot = '{0, 0, 0};
      m_grav = 0; m_rr = 0; m_busy = 1'b0; m_drop = 0; m_flush = 1'b1;
      return;
    end
    if (m_busy && cmd_ack) m_busy = 1'b0;
    if (g >= 0) begin
      exp_q.push_back(m_slot[g]);
      m_slot[g] = 0;
      m_busy = 1'b1;
      m_rr = (g + 1) % 3;
    end
    if (game_over) begin
      m_grav = 0;
      m_slot[0] = 0;
      for (int s = 1; s < 3; s++) if (m_slot[s] != 7) m_slot[s] = 0;
    end else if (m_grav == TICK - 1) begin
      m_grav = 0;
      m_slot[0] = 4;
    end else begin
      m_grav++;
    end
    if (btn_req != 4'd0) begin
      low = 0;
      for (int b = 3; b >= 0; b--) if (btn_req[b]) low = b;
      if (m_slot[1] != 0) m_drop++;
      else begin
        m_slot[1] = (low == 3) ? 5 : low + 1;
        if ($countones(btn_req) > 1) m_drop++;
        if (game_over) m_slot[1] = 0;
      end
      if (m_drop > DMAX) m_drop = DMAX;
    end
    if (uart_valid && rdy && uart_cmd != 3'd0 && (!game_over || uart_cmd == 3'd7))
      m_slot[2] = int'(uart_cmd);
  endtask

  // ackm: 0 = low, 1 = high, 2 = follow cmd_valid
  task automatic applyStimulus(input logic rn, input logic [3:0] b, input logic uv,
                               input logic [2:0] uc, input logic er, input logic go,
                               input int ackm);
    @(posedge clk_50MHz);
    #1;
    if (m_flush) begin
      exp_q.delete();
      m_flush = 1'b0;
    end
    checkOutput("drop_cnt", int'(drop_cnt), m_drop);
    reset_n      = rn;
    btn_req      = b;
    uart_valid   = uv;
    uart_cmd     = uc;
    engine_ready = er;
    game_over    = go;
    cmd_ack      = (ackm == 2) ? cmd_valid : (ackm != 0);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
  endtask

  always @(negedge clk_50MHz) begin
    if (cmd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_cmd: got cmd=%0d offered, expected no offer (t=%0t)", cmd, $time);
      end else begin
        checkOutput("cmd", int'(cmd), exp_q[0]);
        if (cmd_ack) void'(exp_q.pop_front());
      end
    end
  end

  int cnt;
  int cnt2;
  int last;
  logic go_r;
  logic prev_go;
  logic [3:0] rb;

  initial begin
    reset_n = 1'b0; btn_req = 4'd0; uart_valid = 1'b0; uart_cmd = 3'd0;
    engine_ready = 1'b0; game_over = 1'b0; cmd_ack = 1'b0;

    do_reset();
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    checkOutput("rst_cmd_valid", int'(cmd_valid), 0);
    checkOutput("rst_cmd", int'(cmd), 0);
    checkOutput("rst_uart_ready", int'(uart_ready), 1);
    checkOutput("rst_drop_cnt", int'(drop_cnt), 0);

    // Latency: LEFT pulse at N, offer at N+2, held while ack stays low.
    do_reset();
    applyStimulus(1'b1, 4'b0001, 1'b0, 3'd0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 0);
    checkOutput("lat_n1_valid", int'(cmd_valid), 0);
    for (int i = 2; i <= 7; i++) begin
      applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, (i == 7) ? 1 : 0);
      checkOutput("lat_hold_valid", int'(cmd_valid), 1);
      checkOutput("lat_hold_cmd", int'(cmd), 1);
    end
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 0);
    checkOutput("lat_after_ack_valid", int'(cmd_valid), 0);

    // Gravity alone: one-cycle DOWN offer every TICK cycles.
    do_reset();
    cnt = 0; last = -1;
    for (int j = 0; j < 40; j++) begin
      applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 2);
      if (cmd_valid) begin
        cnt++;
        checkOutput("grav_cmd", int'(cmd), 4);
        if (last >= 0) checkOutput("grav_period", j - last, TICK);
        last = j;
      end
    end
    checkOutput("grav_pulses", cnt, 4);

    // Full button slot: extra bits and later pulses are dropped.
    do_reset();
    applyStimulus(1'b1, 4'b0101, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 2);
    checkOutput("drop_two", int'(drop_cnt), 2);
    cnt = 0; cnt2 = 0;
    for (int j = 0; j < 12; j++) begin
      applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 2);
      if (cmd_valid && cmd == 3'd1) cnt++;
      if (cmd_valid && cmd == 3'd2) cnt2++;
    end
    checkOutput("left_issued", cnt, 1);
    checkOutput("right_issued", cnt2, 0);

    // All three slots full with rr at GRAV: DOWN, ROTATE, HOLD.
    do_reset();
    for (int j = 0; j <= 13; j++) begin
      applyStimulus(1'b1, (j == 0) ? 4'b0100 : 4'd0, j == 0, 3'd6, j >= 8, 1'b0, 1);
      if (j == 9 || j == 11 || j == 13) begin
        checkOutput("rr_valid", int'(cmd_valid), 1);
        checkOutput("rr_cmd", int'(cmd), (j == 9) ? 4 : (j == 11) ? 3 : 6);
      end
    end

    // game_over: only the UART RESTART gets through.
    do_reset();
    applyStimulus(1'b1, 4'b0001, 1'b1, 3'd6, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1, 0);
    applyStimulus(1'b1, 4'd0, 1'b1, 3'd7, 1'b0, 1'b1, 0);
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1, 2);
      if (cmd_valid) begin
        cnt++;
        checkOutput("go_cmd", int'(cmd), 7);
      end
    end
    checkOutput("go_offers", cnt, 1);

    // Reset during an offer of DROP.
    do_reset();
    applyStimulus(1'b1, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 0);
    checkOutput("mid_valid", int'(cmd_valid), 1);
    checkOutput("mid_cmd", int'(cmd), 5);
    checkOutput("mid_drop", int'(drop_cnt), 1);
    applyStimulus(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    checkOutput("abort_valid", int'(cmd_valid), 0);
    checkOutput("abort_cmd", int'(cmd), 0);
    checkOutput("abort_uart_ready", int'(uart_ready), 1);
    checkOutput("abort_drop", int'(drop_cnt), 0);

    // Randomised traffic; button pulses stay clear of game_over edges.
    go_r = 1'b0; prev_go = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) go_r = ~go_r;
      rb = 4'd0;
      if (!go_r && !prev_go && $urandom_range(0, 3) == 0) rb = 4'($urandom_range(1, 15));
      applyStimulus(1'b1, rb, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 4) != 0, go_r, int'($urandom_range(0, 1)));
      prev_go = go_r;
    end

    // Saturation of the drop counter.
    do_reset();
    for (int j = 0; j < 20; j++) applyStimulus(1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    checkOutput("drop_saturated", int'(drop_cnt), DMAX);

    for (int j = 0; j < 20; j++) applyStimulus(1'b1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1);
    checkOutput("pending_expected", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
